ofdm_sync_scheduler: RTL and testbench
======================================

# ofdm_sync_scheduler

Sequences the OFDM symbol-sync stage across a frame: holds it in reset while disabled, watches its `pre_sampling` handshake and registered Avalon-ST output, and counts symbols per frame. It checks each symbol's sample count and issues a re-arm reset on a length error or search timeout. It sits beside the symbol-sync block and drives that block's `reset_reset`; its frame/symbol strobes feed the downstream FFT/demap sequencer.

## Interface
- `SYM_LEN`, 64: valid beats per symbol packet (SOP..EOP inclusive), ≥2.
- `SYMS_PER_FRAME`, 16: symbol packets per frame, ≥1.
- `SEARCH_TIMEOUT`, 4096: max cycles in SEARCH before re-arm.
- `RESET_CYCLES`, 4: `sync_reset` pulse width in RECOVER, ≥1.
- `clock_clk`  in  1  clock.
- `reset_reset`  in  1  asynchronous, active-high reset.
- `cfg_enable`  in  1  level; 0 forces IDLE.
- `sync_pre_sampling`  in  1  from sync block; 1 = searching, 0 = locked.
- `sync_valid` / `sync_sop` / `sync_eop`  in  1 each  sync block output stream qualifiers.
- `sync_reset`  out  1  drives sync block reset.
- `frame_active`  out  1  high from first lock of a frame until `frame_done`/abort.
- `sym_index`  out  $clog2(SYMS_PER_FRAME)  index of current/next symbol.
- `sym_start`  out  1  one-cycle strobe per accepted SOP.
- `frame_done`  out  1  one-cycle strobe, last symbol ended with correct length.
- `err_length`  out  1  one-cycle strobe, symbol length mismatch.
- `err_timeout`  out  1  one-cycle strobe, search timeout.
- `frame_count`, `error_count`  out  16 each  statistics (see Configuration).

## Operation
- States: IDLE, RECOVER, SEARCH, LOCKED. `cfg_enable`=0 in any state → IDLE next cycle, counters and `sym_index` cleared, `frame_active`=0.
- IDLE: `sync_reset`=1. `cfg_enable`=1 → RECOVER.
- RECOVER: `sync_reset`=1 for exactly RESET_CYCLES cycles → SEARCH; search timer cleared.
- SEARCH: `sync_reset`=0; timer +1 per cycle while `sync_pre_sampling`=1. `sync_pre_sampling`=0 → LOCKED, beat counter cleared, `frame_active`=1. Timer reaches SEARCH_TIMEOUT → `err_timeout`, RECOVER, `sym_index`=0, `frame_active`=0. Timeout only applies while `frame_active`=0 or between symbols equally (same rule).
- LOCKED: beat counter +1 per `sync_valid` beat. `sym_start` on valid beat with `sync_sop`. On valid beat with `sync_eop`: count (incl. this beat) == SYM_LEN → ok, else `err_length`.
  - ok, `sym_index` < SYMS_PER_FRAME-1 → `sym_index`+1, SEARCH.
  - ok, last → `frame_done`, `sym_index`=0, `frame_active`=0, SEARCH.
  - error → RECOVER, `sym_index`=0, `frame_active`=0.
- Beat count exceeding SYM_LEN without EOP → `err_length` immediately, RECOVER.
- SOP and EOP on same beat: count 1 → `sym_start` and `err_length` both fire.
- SOP while count ≠ 0 (missing EOP): `err_length`, RECOVER.
- Strobes mutually consistent: at most one of `frame_done`/`err_length`/`err_timeout` per cycle.

## Timing
- All outputs registered. Reset values: state IDLE, `sync_reset`=1, all other outputs 0.
- Strobes assert the cycle after the qualifying input beat, width exactly one cycle.
- `sync_reset` deasserts the cycle after RECOVER's last cycle; IDLE→first SEARCH cycle = RESET_CYCLES+1 cycles after `cfg_enable` sampled high.
- Lock detection latency: one cycle from `sync_pre_sampling` falling to LOCKED.
- Reset mid-operation: immediate return to reset values, no strobes emitted.

## Configuration
- `OFDM_SYNC_STATS_EN` defined: `frame_count` +1 per `frame_done`, `error_count` +1 per `err_length` or `err_timeout`; both 16-bit saturating at 16'hFFFF, cleared by reset only.
- Undefined: both ports driven constant 0, no counter logic.

## Structure
- Package `ofdm_sync_pkg`: state enum type, default parameter constants, 16-bit stat width constant.
- One sub-module: `ofdm_sat_counter` (parameterised width, inc, clear, saturate), instantiated twice under the macro.

## Test plan
- Enable, lock, 16 symbols of 64 beats each → 16 `sym_start`, one `frame_done`, `sym_index` returns 0, `frame_count`=1.
- Symbol with 63 beats then EOP → `err_length`, `sync_reset` high 4 cycles, `sym_index`=0.
- `sync_pre_sampling` held 1 for 4096 cycles → `err_timeout` on cycle 4097, RECOVER.
- 65th beat without EOP → `err_length` the following cycle; single-beat SOP+EOP → `sym_start` and `err_length` same cycle.
- `cfg_enable` dropped mid-symbol 7 → IDLE, `sync_reset`=1, no strobes; re-enable restarts at `sym_index` 0.
- `reset_reset` asserted mid-frame → all outputs at reset values asynchronously; 65536 errors → `error_count` saturates at 16'hFFFF.

Source files
------------

// File: rtl/ofdm_sync_pkg.sv
// rtl/ofdm_sync_pkg.sv - shared types and defaults for the OFDM symbol-sync scheduler
package ofdm_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECOVER = 2'd1,
    ST_SEARCH  = 2'd2,
    ST_LOCKED  = 2'd3
  } sync_state_e;

  localparam int unsigned DEF_SYM_LEN        = 64;
  localparam int unsigned DEF_SYMS_PER_FRAME = 16;
  localparam int unsigned DEF_SEARCH_TIMEOUT = 4096;
  localparam int unsigned DEF_RESET_CYCLES   = 4;
  localparam int unsigned STAT_W             = 16;

endpackage

// File: rtl/ofdm_sat_counter.sv
// rtl/ofdm_sat_counter.sv - saturating event counter with synchronous clear
module ofdm_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock_clk,
  input  logic             reset_reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] LP_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LP_MAX)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ofdm_sync_scheduler.sv
// rtl/ofdm_sync_scheduler.sv - frame/symbol sequencer and re-arm control for the OFDM symbol-sync stage
// Optional statistics counters enabled by defining OFDM_SYNC_STATS_EN.
module ofdm_sync_scheduler
  import ofdm_sync_pkg::*;
#(
  parameter int unsigned SYM_LEN        = DEF_SYM_LEN,
  parameter int unsigned SYMS_PER_FRAME = DEF_SYMS_PER_FRAME,
  parameter int unsigned SEARCH_TIMEOUT = DEF_SEARCH_TIMEOUT,
  parameter int unsigned RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int unsigned IDX_W          = (SYMS_PER_FRAME > 1) ? $clog2(SYMS_PER_FRAME) : 1
) (
  input  logic              clock_clk,
  input  logic              reset_reset,
  input  logic              cfg_enable,
  input  logic              sync_pre_sampling,
  input  logic              sync_valid,
  input  logic              sync_sop,
  input  logic              sync_eop,
  output logic              sync_reset,
  output logic              frame_active,
  output logic [IDX_W-1:0]  sym_index,
  output logic              sym_start,
  output logic              frame_done,
  output logic              err_length,
  output logic              err_timeout,
  output logic [STAT_W-1:0] frame_count,
  output logic [STAT_W-1:0] error_count
);

  localparam int unsigned BEAT_W = $clog2(SYM_LEN + 2);
  localparam int unsigned TMR_W  = $clog2(SEARCH_TIMEOUT + 1);
  localparam int unsigned RST_W  = $clog2(RESET_CYCLES + 1);

  localparam logic [BEAT_W-1:0] LP_SYM_LEN  = BEAT_W'(SYM_LEN);
  localparam logic [TMR_W-1:0]  LP_TMR_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
  localparam logic [RST_W-1:0]  LP_RST_LAST = RST_W'(RESET_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LP_IDX_LAST = IDX_W'(SYMS_PER_FRAME - 1);

  sync_state_e       r_state;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [TMR_W-1:0]  r_timer;
  logic [RST_W-1:0]  r_rst_cnt;
  logic [IDX_W-1:0]  r_sym_index;
  logic              r_sync_reset;
  logic              r_frame_active;
  logic              r_sym_start;
  logic              r_frame_done;
  logic              r_err_length;
  logic              r_err_timeout;

  logic [BEAT_W-1:0] w_beat_next;

  // Count including the beat being presented now.
  assign w_beat_next = r_beat_cnt + BEAT_W'(1);

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state        <= ST_IDLE;
      r_beat_cnt     <= '0;
      r_timer        <= '0;
      r_rst_cnt      <= '0;
      r_sym_index    <= '0;
      r_sync_reset   <= 1'b1;
      r_frame_active <= 1'b0;
      r_sym_start    <= 1'b0;
      r_frame_done   <= 1'b0;
      r_err_length   <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_sym_start   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err_length  <= 1'b0;
      r_err_timeout <= 1'b0;

      if (!cfg_enable) begin
        r_state        <= ST_IDLE;
        r_sync_reset   <= 1'b1;
        r_frame_active <= 1'b0;
        r_sym_index    <= '0;
        r_beat_cnt     <= '0;
        r_timer        <= '0;
        r_rst_cnt      <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state      <= ST_RECOVER;
            r_rst_cnt    <= '0;
            r_sync_reset <= 1'b1;
          end

          ST_RECOVER: begin
            if (r_rst_cnt == LP_RST_LAST) begin
              r_state      <= ST_SEARCH;
              r_sync_reset <= 1'b0;
              r_timer      <= '0;
            end else begin
              r_rst_cnt <= r_rst_cnt + RST_W'(1);
            end
          end

          ST_SEARCH: begin
            if (!sync_pre_sampling) begin
              r_state        <= ST_LOCKED;
              r_beat_cnt     <= '0;
              r_frame_active <= 1'b1;
            end else if (r_timer == LP_TMR_LAST) begin
              r_err_timeout  <= 1'b1;
              r_state        <= ST_RECOVER;
              r_rst_cnt      <= '0;
              r_sync_reset   <= 1'b1;
              r_sym_index    <= '0;
              r_frame_active <= 1'b0;
            end else begin
              r_timer <= r_timer + TMR_W'(1);
            end
          end

          ST_LOCKED: begin
            if (sync_valid) begin
              // A new SOP before the previous EOP means the sync block slipped.
              if (sync_sop && (r_beat_cnt != '0)) begin
                r_err_length   <= 1'b1;
                r_state        <= ST_RECOVER;
                r_rst_cnt      <= '0;
                r_sync_reset   <= 1'b1;
                r_sym_index    <= '0;
                r_frame_active <= 1'b0;
              end else begin
                r_sym_start <= sync_sop;
                if (sync_eop && (w_beat_next == LP_SYM_LEN)) begin
                  r_state <= ST_SEARCH;
                  r_timer <= '0;
                  if (r_sym_index == LP_IDX_LAST) begin
                    r_frame_done   <= 1'b1;
                    r_sym_index    <= '0;
                    r_frame_active <= 1'b0;
                  end else begin
                    r_sym_index <= r_sym_index + IDX_W'(1);
                  end
                end else if (sync_eop || (w_beat_next > LP_SYM_LEN)) begin
                  r_err_length   <= 1'b1;
                  r_state        <= ST_RECOVER;
                  r_rst_cnt      <= '0;
                  r_sync_reset   <= 1'b1;
                  r_sym_index    <= '0;
                  r_frame_active <= 1'b0;
                end else begin
                  r_beat_cnt <= w_beat_next;
                end
              end
            end
          end

          default: begin
            r_state      <= ST_IDLE;
            r_sync_reset <= 1'b1;
          end
        endcase
      end
    end
  end

  assign sync_reset   = r_sync_reset;
  assign frame_active = r_frame_active;
  assign sym_index    = r_sym_index;
  assign sym_start    = r_sym_start;
  assign frame_done   = r_frame_done;
  assign err_length   = r_err_length;
  assign err_timeout  = r_err_timeout;

`ifdef OFDM_SYNC_STATS_EN
  logic [STAT_W-1:0] w_frame_count;
  logic [STAT_W-1:0] w_error_count;

  ofdm_sat_counter #(.WIDTH(STAT_W)) u_frame_cnt (
    .clock_clk   (clock_clk),
    .reset_reset (reset_reset),
    .i_clear     (1'b0),
    .i_inc       (r_frame_done),
    .o_count     (w_frame_count)
  );

  ofdm_sat_counter #(.WIDTH(STAT_W)) u_error_cnt (
    .clock_clk   (clock_clk),
    .reset_reset (reset_reset),
    .i_clear     (1'b0),
    .i_inc       (r_err_length | r_err_timeout),
    .o_count     (w_error_count)
  );

  assign frame_count = w_frame_count;
  assign error_count = w_error_count;
`else
  assign frame_count = '0;
  assign error_count = '0;
`endif

endmodule

// File: tb/tb_ofdm_sync_scheduler.sv
// tb/tb_ofdm_sync_scheduler.sv - directed self-checking bench for ofdm_sync_scheduler
module tb_ofdm_sync_scheduler;

  logic        clock_clk = 1'b0;
  logic        reset_reset;
  logic        cfg_enable;
  logic        sync_pre_sampling;
  logic        sync_valid;
  logic        sync_sop;
  logic        sync_eop;
  logic        sync_reset;
  logic        frame_active;
  logic [3:0]  sym_index;
  logic        sym_start;
  logic        frame_done;
  logic        err_length;
  logic        err_timeout;
  logic [15:0] frame_count;
  logic [15:0] error_count;

  logic        sc_clear;
  logic        sc_inc;
  logic [3:0]  sc_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_ss = 0;
  int n_fd = 0;
  int n_el = 0;
  int n_to = 0;
  int n_excl = 0;
  int snap_el;

`ifdef OFDM_SYNC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clock_clk = ~clock_clk;

  ofdm_sync_scheduler dut (
    .clock_clk         (clock_clk),
    .reset_reset       (reset_reset),
    .cfg_enable        (cfg_enable),
    .sync_pre_sampling (sync_pre_sampling),
    .sync_valid        (sync_valid),
    .sync_sop          (sync_sop),
    .sync_eop          (sync_eop),
    .sync_reset        (sync_reset),
    .frame_active      (frame_active),
    .sym_index         (sym_index),
    .sym_start         (sym_start),
    .frame_done        (frame_done),
    .err_length        (err_length),
    .err_timeout       (err_timeout),
    .frame_count       (frame_count),
    .error_count       (error_count)
  );

  ofdm_sat_counter #(.WIDTH(4)) u_sc (
    .clock_clk   (clock_clk),
    .reset_reset (reset_reset),
    .i_clear     (sc_clear),
    .i_inc       (sc_inc),
    .o_count     (sc_count)
  );

  always @(negedge clock_clk) begin
    if (sym_start)   n_ss++;
    if (frame_done)  n_fd++;
    if (err_length)  n_el++;
    if (err_timeout) n_to++;
    if ((32'(frame_done) + 32'(err_length) + 32'(err_timeout)) > 1) n_excl++;
  end

  task automatic tick();
    @(posedge clock_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input bit sop, input bit eop);
    sync_valid = 1'b1;
    sync_sop   = sop;
    sync_eop   = eop;
    tick();
    sync_valid = 1'b0;
    sync_sop   = 1'b0;
    sync_eop   = 1'b0;
  endtask

  task automatic send_sym(input int n, input bit with_eop);
    for (int i = 0; i < n; i++) beat(i == 0, with_eop && (i == n - 1));
  endtask

  // Called just after the edge that entered RECOVER: 4 cycles of sync_reset, then SEARCH.
  task automatic expect_recover(input string tag, input bit lock);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_rst_hi"}, sync_reset, 1'b1);
    end
    tick();
    chk({tag, "_rst_lo"}, sync_reset, 1'b0);
    if (lock) begin
      tick();
      chk({tag, "_locked"}, frame_active, 1'b1);
    end
  endtask

  initial begin
    reset_reset       = 1'b1;
    cfg_enable        = 1'b0;
    sync_pre_sampling = 1'b1;
    sync_valid        = 1'b0;
    sync_sop          = 1'b0;
    sync_eop          = 1'b0;
    sc_clear          = 1'b0;
    sc_inc            = 1'b0;
    repeat (3) tick();

    chk("rst_sync_reset", sync_reset, 1'b1);
    chk("rst_frame_active", frame_active, 1'b0);
    chk("rst_sym_index", sym_index, 4'd0);
    chk("rst_strobes", {sym_start, frame_done, err_length, err_timeout}, 4'b0000);
    chk("rst_counts", {frame_count, error_count}, 32'd0);

    reset_reset = 1'b0;
    tick();
    chk("idle_sync_reset", sync_reset, 1'b1);

    // Enable and lock
    cfg_enable = 1'b1;
    tick();
    chk("en_rst_first", sync_reset, 1'b1);
    sync_pre_sampling = 1'b0;
    expect_recover("en", 1'b1);

    // Full frame of 16 x 64 beats
    for (int s = 0; s < 16; s++) begin
      chk($sformatf("frm_idx%0d", s), sym_index, s);
      send_sym(64, 1'b1);
      chk($sformatf("frm_done%0d", s), frame_done, (s == 15));
      tick();
    end
    chk("frm_n_sym_start", n_ss, 16);
    chk("frm_n_frame_done", n_fd, 1);
    chk("frm_idx_wrap", sym_index, 4'd0);
    chk("frm_relock", frame_active, 1'b1);
    chk("frm_frame_count", frame_count, STATS ? 16'd1 : 16'd0);
    chk("frm_no_err", n_el + n_to, 0);

    // 63-beat symbol
    send_sym(63, 1'b1);
    chk("short_err", err_length, 1'b1);
    chk("short_rst", sync_reset, 1'b1);
    chk("short_idx", sym_index, 4'd0);
    chk("short_active", frame_active, 1'b0);
    expect_recover("short", 1'b1);

    // 65th beat without EOP
    send_sym(64, 1'b0);
    chk("long_no_err_yet", err_length, 1'b0);
    beat(1'b0, 1'b0);
    chk("long_err", err_length, 1'b1);
    chk("long_rst", sync_reset, 1'b1);
    expect_recover("long", 1'b1);

    // Single-beat SOP+EOP, then search timeout
    beat(1'b1, 1'b1);
    chk("one_sym_start", sym_start, 1'b1);
    chk("one_err", err_length, 1'b1);
    sync_pre_sampling = 1'b1;
    expect_recover("one", 1'b0);
    repeat (4095) tick();
    chk("to_not_yet", err_timeout, 1'b0);
    tick();
    chk("to_fire", err_timeout, 1'b1);
    chk("to_rst", sync_reset, 1'b1);
    chk("to_active", frame_active, 1'b0);
    sync_pre_sampling = 1'b0;
    expect_recover("to", 1'b1);
    chk("to_err_count", error_count, STATS ? 16'd4 : 16'd0);

    // Disable mid-symbol 7
    for (int s = 0; s < 7; s++) begin
      send_sym(64, 1'b1);
      tick();
    end
    chk("dis_idx7", sym_index, 4'd7);
    send_sym(30, 1'b0);
    snap_el = n_el;
    cfg_enable = 1'b0;
    beat(1'b0, 1'b1);
    chk("dis_rst", sync_reset, 1'b1);
    chk("dis_idx", sym_index, 4'd0);
    chk("dis_active", frame_active, 1'b0);
    send_sym(5, 1'b1);
    chk("dis_rst_hold", sync_reset, 1'b1);
    chk("dis_no_strobe", n_el - snap_el, 0);
    cfg_enable = 1'b1;
    tick();
    chk("reen_rst", sync_reset, 1'b1);
    expect_recover("reen", 1'b1);
    chk("reen_idx0", sym_index, 4'd0);
    send_sym(64, 1'b1);
    chk("reen_idx1", sym_index, 4'd1);
    tick();

    // Asynchronous reset mid-frame
    send_sym(10, 1'b0);
    reset_reset = 1'b1;
    #2;
    chk("arst_sync_reset", sync_reset, 1'b1);
    chk("arst_active", frame_active, 1'b0);
    chk("arst_idx", sym_index, 4'd0);
    chk("arst_counts", {frame_count, error_count}, 32'd0);
    tick();
    reset_reset = 1'b0;
    tick();

    // Saturation of the counter building block
    sc_inc = 1'b1;
    repeat (20) tick();
    sc_inc = 1'b0;
    chk("sat_max", sc_count, 4'hF);
    sc_clear = 1'b1;
    tick();
    sc_clear = 1'b0;
    chk("sat_clear", sc_count, 4'h0);

    chk("strobe_exclusive", n_excl, 0);
    chk("n_timeouts", n_to, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
